// File: rtl/fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_seq_ctrl
// Sequencer for an in-place radix-2 DIT FFT engine with one shared butterfly
// and a dual-port sample RAM. A run has four phases:
//   LOAD    - N cycles of bit-reversed input writes
//   COMPUTE - LOG2N stages, each N/2 issue cycles followed by BF_LAT drain cycles
//   UNLOAD  - N cycles of natural-order reads
//   DONE    - one cycle, then the FSM returns to IDLE
//
// Optional feature: define FFT_SEQ_CTRL_INVERSE_EN to add the `inverse` input
// (latched when a run starts) and the `tw_conj` output (held for the whole run).
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start                      run request, sampled only in IDLE
//   busy, done                 status; done is a one-cycle pulse in DONE
//   ld_we, ld_idx, ld_addr     input load: natural index, bit-reversed address
//   bf_issue, rd_addr_a/b      butterfly issue strobe and operand addresses
//   tw_idx                     twiddle ROM index (W_N^tw_idx)
//   wb_we, wb_addr_a/b         issue strobe/addresses delayed by BF_LAT cycles
//   out_valid, out_addr        unload strobe and natural-order read address
// -----------------------------------------------------------------------------
module fft_seq_ctrl #(
  parameter int N      = 16,
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FFT_SEQ_CTRL_INVERSE_EN
  input  logic             inverse,
  output logic             tw_conj,
`endif
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ld_we,
  output logic [LOG2N-1:0] ld_idx,
  output logic [LOG2N-1:0] ld_addr,
  output logic             bf_issue,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wb_we,
  output logic [LOG2N-1:0] wb_addr_a,
  output logic [LOG2N-1:0] wb_addr_b,
  output logic             out_valid,
  output logic [LOG2N-1:0] out_addr
);

  // Counter must hold both N-1 and N/2+BF_LAT-1 (the latter dominates for small N).
  localparam int CW      = LOG2N + 4;
  localparam int SW      = $clog2(LOG2N) + 1;
  localparam int HALF    = N / 2;
  localparam int STG_LEN = HALF + BF_LAT;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SW-1:0]   stage, stage_nxt;
  logic            issue_nxt;
  logic [LOG2N-1:0] k_nxt;

  logic [BF_LAT-1:0]            wb_we_sr;
  logic [BF_LAT-1:0][LOG2N-1:0] wb_a_sr;
  logic [BF_LAT-1:0][LOG2N-1:0] wb_b_sr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic [LOG2N-1:0] low_pos(input logic [LOG2N-1:0] k,
                                               input logic [SW-1:0] s);
    return k & ((LOG2N'(1) << s) - LOG2N'(1));
  endfunction

  // Group index (k>>s) spaced by 2*span, plus position inside the group.
  function automatic logic [LOG2N-1:0] addr_a(input logic [LOG2N-1:0] k,
                                              input logic [SW-1:0] s);
    return ((k >> s) << (s + SW'(1))) + low_pos(k, s);
  endfunction

  function automatic logic [LOG2N-1:0] addr_b(input logic [LOG2N-1:0] k,
                                              input logic [SW-1:0] s);
    return addr_a(k, s) + (LOG2N'(1) << s);
  endfunction

  function automatic logic [LOG2N-2:0] tw_of(input logic [LOG2N-1:0] k,
                                             input logic [SW-1:0] s);
    return (LOG2N-1)'(low_pos(k, s) << (SW'(LOG2N-1) - s));
  endfunction

  // Next-state logic; outputs are registered from these next values so they
  // line up with the cycle the FSM occupies the corresponding state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stage_nxt = stage;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
          stage_nxt = '0;
        end
      end
      S_LOAD: begin
        if (cnt == CW'(N-1)) begin
          state_nxt = S_COMPUTE;
          cnt_nxt   = '0;
          stage_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (cnt == CW'(STG_LEN-1)) begin
          cnt_nxt = '0;
          if (stage == SW'(LOG2N-1)) state_nxt = S_UNLOAD;
          else                       stage_nxt = stage + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (cnt == CW'(N-1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign issue_nxt = (state_nxt == S_COMPUTE) && (cnt_nxt < CW'(HALF));
  assign k_nxt     = cnt_nxt[LOG2N-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      stage <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      stage <= stage_nxt;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      ld_we     <= 1'b0;
      ld_idx    <= '0;
      ld_addr   <= '0;
      bf_issue  <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
    end else begin
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      ld_we     <= (state_nxt == S_LOAD);
      ld_idx    <= (state_nxt == S_LOAD) ? k_nxt : '0;
      ld_addr   <= (state_nxt == S_LOAD) ? bitrev(k_nxt) : '0;
      bf_issue  <= issue_nxt;
      rd_addr_a <= issue_nxt ? addr_a(k_nxt, stage_nxt) : '0;
      rd_addr_b <= issue_nxt ? addr_b(k_nxt, stage_nxt) : '0;
      tw_idx    <= issue_nxt ? tw_of(k_nxt, stage_nxt) : '0;
      out_valid <= (state_nxt == S_UNLOAD);
      out_addr  <= (state_nxt == S_UNLOAD) ? k_nxt : '0;
    end
  end

  // ---- writeback delay stage: BF_LAT cycles behind the issue registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_sr <= '0;
      wb_a_sr  <= '0;
      wb_b_sr  <= '0;
    end else begin
      wb_we_sr[0] <= bf_issue;
      wb_a_sr[0]  <= rd_addr_a;
      wb_b_sr[0]  <= rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        wb_we_sr[i] <= wb_we_sr[i-1];
        wb_a_sr[i]  <= wb_a_sr[i-1];
        wb_b_sr[i]  <= wb_b_sr[i-1];
      end
    end
  end

  assign wb_we     = wb_we_sr[BF_LAT-1];
  assign wb_addr_a = wb_a_sr[BF_LAT-1];
  assign wb_addr_b = wb_b_sr[BF_LAT-1];

`ifdef FFT_SEQ_CTRL_INVERSE_EN
  // Direction is captured once per run; later changes of `inverse` are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           tw_conj <= 1'b0;
    else if (state == S_IDLE && start) tw_conj <= inverse;
  end
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_seq_ctrl
// Scoreboard bench for fft_seq_ctrl (N=16, LOG2N=4, BF_LAT=2). A reference
// model builds the full per-cycle output trace of a run and queues it when the
// run is started; each cycle the observed outputs are compared against the
// popped entry.
// -----------------------------------------------------------------------------
module tb_fft_seq_ctrl;
  localparam int N      = 16;
  localparam int LOG2N  = 4;
  localparam int BF_LAT = 2;
  localparam int RUN    = 2*N + LOG2N*(N/2 + BF_LAT) + 1;

  typedef struct packed {
    logic [63-5-8*LOG2N:0] pad;
    logic             busy;
    logic             done;
    logic             ld_we;
    logic [LOG2N-1:0] ld_idx;
    logic [LOG2N-1:0] ld_addr;
    logic             bf_issue;
    logic [LOG2N-1:0] rd_a;
    logic [LOG2N-1:0] rd_b;
    logic [LOG2N-2:0] tw;
    logic             wb_we;
    logic [LOG2N-1:0] wb_a;
    logic [LOG2N-1:0] wb_b;
    logic             out_valid;
    logic [LOG2N-1:0] out_addr;
  } trace_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, ld_we, bf_issue, wb_we, out_valid;
  logic [LOG2N-1:0] ld_idx, ld_addr, rd_addr_a, rd_addr_b, wb_addr_a, wb_addr_b, out_addr;
  logic [LOG2N-2:0] tw_idx;
`ifdef FFT_SEQ_CTRL_INVERSE_EN
  logic inverse = 1'b0;
  logic tw_conj;
  logic exp_conj = 1'b0;
`endif

  always #5 clk = ~clk;

  fft_seq_ctrl #(.N(N), .LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FFT_SEQ_CTRL_INVERSE_EN
    .inverse   (inverse),
    .tw_conj   (tw_conj),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ld_we     (ld_we),
    .ld_idx    (ld_idx),
    .ld_addr   (ld_addr),
    .bf_issue  (bf_issue),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wb_we     (wb_we),
    .wb_addr_a (wb_addr_a),
    .wb_addr_b (wb_addr_b),
    .out_valid (out_valid),
    .out_addr  (out_addr)
  );

  trace_t obs;
  always_comb begin
    obs           = '0;
    obs.busy      = busy;
    obs.done      = done;
    obs.ld_we     = ld_we;
    obs.ld_idx    = ld_idx;
    obs.ld_addr   = ld_addr;
    obs.bf_issue  = bf_issue;
    obs.rd_a      = rd_addr_a;
    obs.rd_b      = rd_addr_b;
    obs.tw        = tw_idx;
    obs.wb_we     = wb_we;
    obs.wb_a      = wb_addr_a;
    obs.wb_b      = wb_addr_b;
    obs.out_valid = out_valid;
    obs.out_addr  = out_addr;
  end

  int n_tests = 0;
  int n_fail  = 0;
  trace_t sb_q[$];
  trace_t rec[0:255];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++)
      if (((v >> i) & 1) != 0) r |= (1 << (LOG2N-1-i));
    return r;
  endfunction

  // Reference trace for one run: cycles 1..RUN, plus the IDLE cycle after DONE.
  task automatic push_run();
    int iss[RUN+2];
    int ra[RUN+2];
    int rb[RUN+2];
    int c_end, u, s, k, span, pos;
    trace_t e;
    c_end = N + LOG2N*(N/2 + BF_LAT);
    for (int t = 0; t < RUN+2; t++) begin
      iss[t] = 0; ra[t] = 0; rb[t] = 0;
    end
    for (int t = 1; t <= RUN+1; t++) begin
      e      = '0;
      e.busy = (t <= RUN);
      e.done = (t == RUN);
      if (t <= N) begin
        e.ld_we   = 1'b1;
        e.ld_idx  = LOG2N'(t-1);
        e.ld_addr = LOG2N'(rev(t-1));
      end else if (t <= c_end) begin
        u = t - N - 1;
        s = u / (N/2 + BF_LAT);
        k = u % (N/2 + BF_LAT);
        if (k < N/2) begin
          span       = 1 << s;
          pos        = k % span;
          iss[t]     = 1;
          ra[t]      = (k / span) * 2 * span + pos;
          rb[t]      = ra[t] + span;
          e.bf_issue = 1'b1;
          e.rd_a     = LOG2N'(ra[t]);
          e.rd_b     = LOG2N'(rb[t]);
          e.tw       = (LOG2N-1)'(pos * ((N/2) / span));
        end
      end else if (t <= c_end + N) begin
        e.out_valid = 1'b1;
        e.out_addr  = LOG2N'(t - c_end - 1);
      end
      if (t > BF_LAT && iss[t-BF_LAT] != 0) begin
        e.wb_we = 1'b1;
        e.wb_a  = LOG2N'(ra[t-BF_LAT]);
        e.wb_b  = LOG2N'(rb[t-BF_LAT]);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic compare_cycles(input int first, input int last, input string name);
    trace_t e;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      rec[i] = obs;
      check_eq($sformatf("%s_sb_nonempty_c%0d", name, i), 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq($sformatf("%s_c%0d", name, i), obs, e);
      end
`ifdef FFT_SEQ_CTRL_INVERSE_EN
      check_eq($sformatf("%s_tw_conj_c%0d", name, i), 64'(tw_conj), 64'(exp_conj));
`endif
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    push_run();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  logic [LOG2N-1:0] ld_tab [16];

  initial begin
    ld_tab = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
               4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_outs", obs, 64'd0);
`ifdef FFT_SEQ_CTRL_INVERSE_EN
    check_eq("reset_tw_conj", 64'(tw_conj), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Run 1: full trace; direction input toggled mid-run
`ifdef FFT_SEQ_CTRL_INVERSE_EN
    inverse  = 1'b1;
    exp_conj = 1'b1;
`endif
    pulse_start();
    compare_cycles(1, 30, "run1");
`ifdef FFT_SEQ_CTRL_INVERSE_EN
    inverse = 1'b0;
`endif
    compare_cycles(31, RUN+1, "run1");

    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("ld_addr_seq%0d", i), 64'(rec[i+1].ld_addr), 64'(ld_tab[i]));
      check_eq($sformatf("ld_idx_seq%0d", i), 64'(rec[i+1].ld_idx), 64'(i));
    end
    check_eq("s0k3_a",  64'(rec[20].rd_a), 64'd6);
    check_eq("s0k3_b",  64'(rec[20].rd_b), 64'd7);
    check_eq("s0k3_tw", 64'(rec[20].tw),   64'd0);
    check_eq("s2k5_a",  64'(rec[42].rd_a), 64'd9);
    check_eq("s2k5_b",  64'(rec[42].rd_b), 64'd13);
    check_eq("s2k5_tw", 64'(rec[42].tw),   64'd2);
    check_eq("s3k7_a",  64'(rec[54].rd_a), 64'd7);
    check_eq("s3k7_b",  64'(rec[54].rd_b), 64'd15);
    check_eq("s3k7_tw", 64'(rec[54].tw),   64'd7);
    check_eq("done_c73", 64'(rec[73].done), 64'd1);
    check_eq("busy_c74", 64'(rec[74].busy), 64'd0);

    // Run 2: start during COMPUTE is ignored, then reset at cycle 30
`ifdef FFT_SEQ_CTRL_INVERSE_EN
    exp_conj = 1'b0;
`endif
    pulse_start();
    compare_cycles(1, 24, "run2");
    start = 1'b1;
    compare_cycles(25, 25, "run2");
    start = 1'b0;
    compare_cycles(26, 29, "run2");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_async_outs", obs, 64'd0);
`ifdef FFT_SEQ_CTRL_INVERSE_EN
    check_eq("rst_async_tw_conj", 64'(tw_conj), 64'd0);
`endif
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_after_rst", obs, 64'd0);

    // Run 3: fresh run after reset
    pulse_start();
    compare_cycles(1, RUN+1, "run3");

    // Run 4: start held high through DONE gives back-to-back runs
    start = 1'b1;
    push_run();
    push_run();
    @(posedge clk);
    compare_cycles(1, RUN+2, "b2b");
    start = 1'b0;
    compare_cycles(RUN+3, 2*RUN+2, "b2b");

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencer for the in-place radix-2 decimation-in-time FFT engine. A single shared butterfly unit and a dual-port sample RAM are time-multiplexed across all stages of an N-point transform. The block drives every RAM address, write enable, twiddle index and butterfly issue strobe for the whole run:

- load the input with bit-reversed write addressing;
- run the log2(N) butterfly stages;
- unload the result in natural order;
- pulse `done`, which `fft_core_top` exposes to the system.

## Interface
- `N`, 16: transform length, a power of two, 4..1024.
- `LOG2N`, 4: log2(N); must be consistent with `N`.
- `BF_LAT`, 2: butterfly pipeline latency in cycles, from issue to writeback, 1..8.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `ld_we`  out  1  RAM write enable for input load.
- `ld_idx`  out  LOG2N  input sample index to fetch, natural order.
- `ld_addr`  out  LOG2N  RAM write address, equal to bitrev(`ld_idx`).
- `bf_issue`  out  1  butterfly issue strobe; RAM read port valid.
- `rd_addr_a`, `rd_addr_b`  out  LOG2N each  butterfly operand addresses.
- `tw_idx`  out  LOG2N-1  twiddle ROM index, W_N^`tw_idx`.
- `wb_we`  out  1  butterfly result write enable.
- `wb_addr_a`, `wb_addr_b`  out  LOG2N each  result addresses.
- `out_valid`  out  1  unload strobe.
- `out_addr`  out  LOG2N  RAM read address for unload, natural order.

## Operation
- States and transitions:
  - IDLE → LOAD when `start` = 1.
  - LOAD → COMPUTE after N cycles.
  - COMPUTE → UNLOAD after the last stage has drained.
  - UNLOAD → DONE after N cycles.
  - DONE → IDLE unconditionally.
- LOAD: counter c runs 0..N-1, one value per cycle. Drives `ld_we` = 1, `ld_idx` = c, `ld_addr` = bitrev(c) over LOG2N bits.
- COMPUTE, issue phase: for stage s = 0..LOG2N-1, butterfly k = 0..N/2-1, one butterfly per cycle, with `bf_issue` = 1 and:
  - span = 2^s, pos = k & (span-1);
  - `rd_addr_a` = ((k>>s) << (s+1)) + pos;
  - `rd_addr_b` = `rd_addr_a` + span;
  - `tw_idx` = pos << (LOG2N-1-s).
- COMPUTE, drain phase: after each stage's N/2 issue cycles, BF_LAT cycles with `bf_issue` = 0. This prevents read-after-write hazards across stages.
- Writeback path: `wb_we`, `wb_addr_a` and `wb_addr_b` are copies of `bf_issue`, `rd_addr_a` and `rd_addr_b` delayed by exactly BF_LAT cycles through a shift register.
- UNLOAD: counter runs 0..N-1 with `out_valid` = 1 and `out_addr` = counter value.
- `start` while busy is ignored and has no side effects.
- Reset:
  - Returns to IDLE immediately, including mid-run.
  - Every output resets to 0 and the writeback shift register clears.
  - A new `start` after reset begins a full fresh run; there is no resume.

## Timing
- All outputs are registered and valid in the cycle the FSM is in the corresponding state.
- Edge E0 samples `start` = 1. With that reference, for N = 16 and BF_LAT = 2:
  - LOAD occupies cycles 1..16.
  - COMPUTE occupies cycles 17..56 (4 stages × 10 cycles).
  - UNLOAD occupies cycles 57..72.
  - DONE is cycle 73.
- General run length, from the first LOAD cycle to DONE inclusive: 2N + LOG2N·(N/2+BF_LAT) + 1 cycles.
- Last `wb_we` of a stage is asserted in that stage's final drain cycle. The first `bf_issue` of the next stage follows in the next cycle.
- `done` = 1 for exactly one cycle, with `busy` = 1 in that same cycle. `busy` = 0 from the following cycle.
- Back-to-back runs: a `start` held high through DONE is accepted in the IDLE cycle after DONE.

## Configuration
- `FFT_SEQ_CTRL_INVERSE_EN` defined:
  - Adds input port `inverse` (1 bit), latched on the IDLE→LOAD transition.
  - Adds output `tw_conj`, equal to the latched value for the whole run. It selects conjugated twiddles for an IFFT; 1/N scaling is external.
- Undefined: neither port exists, and the transform is always forward.

## Test plan
- Reset, then `start` pulse, N = 16, BF_LAT = 2 → `busy` rises the next cycle; `done` is high only in cycle 73; `busy` falls in cycle 74.
- LOAD check → `ld_addr` sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 while `ld_idx` counts 0..15.
- Stage address check:
  - Stage 0, k = 3 → `rd_addr_a`/`rd_addr_b` = 6/7, `tw_idx` = 0.
  - Stage 2, k = 5 → addresses 9/13, `tw_idx` = 2.
  - Stage 3, k = 7 → addresses 7/15, `tw_idx` = 7.
- Writeback alignment → `wb_we`, `wb_addr_a` and `wb_addr_b` match the issued values exactly 2 cycles later. No `bf_issue` of stage s+1 occurs before the last `wb_we` of stage s.
- `start` pulsed during COMPUTE, then `rst` asserted at cycle 30 → the mid-run `start` has no effect; after reset all outputs are 0 and the state is IDLE. A later `start` gives `done` 73 cycles after its sampling edge.
- With `FFT_SEQ_CTRL_INVERSE_EN`: `inverse` = 1 at start, toggled mid-run → `tw_conj` = 1 for the entire run. A second run with `inverse` = 0 → `tw_conj` = 0.
